// File: rtl/instr_fetch_unit.sv
// Fetch stage: in-order imem requests, prefetch FIFO, PC redirect and flush.
// Define IFETCH_BOOT_EN to start fetching at BOOT_PC straight out of reset.
module instr_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter logic [ADDR_W-1:0] BOOT_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_pc,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              request_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int DW = 8;

`ifdef IFETCH_BOOT_EN
    localparam bit BOOT_EN = 1'b1;
`else
    localparam bit BOOT_EN = 1'b0;
`endif

    typedef enum logic {
        WAIT_PC,
        RUN
    } state_e;

    localparam state_e RST_STATE = BOOT_EN ? RUN : WAIT_PC;
    localparam logic [ADDR_W-1:0] RST_PC = BOOT_EN ? BOOT_PC : '0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [DW-1:0]     discard_q, discard_d;
    logic              req_q, req_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];

    logic          flush;
    logic          grant;
    logic          push;
    logic          pop;
    logic [CW:0]   credit;

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = data_q[rptr_q];
    assign instr_pc    = pc_q[rptr_q];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        push       = 1'b0;
        flush      = set_pc || (state_q == RUN && request_pc);
        imem_req   = req_q && !flush;
        grant      = imem_req && imem_gnt;
        pop        = instr_valid && instr_ready && !flush;

        if (flush) begin
            state_d = set_pc ? RUN : WAIT_PC;
            if (set_pc) begin
                fetch_pc_d = new_pc;
                resp_pc_d  = new_pc;
            end
            // Everything outstanding now belongs to the old stream
            discard_d  = discard_q + DW'(inflight_q) + DW'(grant)
                       - DW'(imem_rvalid);
            inflight_d = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            if (imem_rvalid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - DW'(1);
                end else begin
                    push = 1'b1;
                end
            end
            inflight_d = inflight_q + CW'(grant) - CW'(push);
            if (push) begin
                wptr_d    = wptr_q + PW'(1);
                resp_pc_d = resp_pc_q + ADDR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // Credit only shrinks without a grant, so a raised request stays legal
        credit = {1'b0, count_d} + {1'b0, inflight_d};
        req_d  = (state_d == RUN) && (credit < (CW+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_STATE;
            fetch_pc_q <= RST_PC;
            resp_pc_q  <= RST_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            req_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            req_q      <= req_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            if (push) begin
                data_q[wptr_q] <= imem_rdata;
                pc_q[wptr_q]   <= resp_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: epoch-tagged memory model plus delivery scoreboard.
// Honours IFETCH_BOOT_EN (BOOT_PC = 0x0040) when the macro is defined.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [15:0] BOOT = 16'h0040;

    logic        clk;
    logic        rst;
    logic        set_pc;
    logic [15:0] new_pc;
    logic        request_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    instr_fetch_unit #(
        .ADDR_W(16),
        .DATA_W(32),
        .DEPTH(DEPTH),
        .BOOT_PC(BOOT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .set_pc(set_pc),
        .new_pc(new_pc),
        .request_pc(request_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    typedef struct {
        logic [15:0] addr;
        int          ep;
        int          due;
    } req_t;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] w;
    } exp_t;

    req_t        outq[$];
    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          ngrants = 0;
    bit          running;
    bit          mon_en = 0;
    bit          prev_pend = 0;
    logic [15:0] prev_addr = '0;
    logic [15:0] next_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hC3A5, ~a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic int cur_out();
        int n = 0;
        foreach (outq[i]) if (outq[i].ep == epoch) n++;
        return n;
    endfunction

    // One clock of stimulus plus the reference model update
    task automatic tick(input bit sp, input logic [15:0] np, input bit rp,
                        input bit rdy, input bit gnt);
        bit   flush;
        bit   g;
        bit   rv;
        req_t r;
        @(negedge clk);
        set_pc      = sp;
        new_pc      = np;
        request_pc  = rp;
        instr_ready = rdy;
        imem_gnt    = gnt;
        rv          = (outq.size() > 0) && (outq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(outq[0].addr) : $urandom;
        #1;
        flush = sp || (rp && running);
        g     = imem_req && gnt;
        if (!running) chk("idle_req", {31'd0, imem_req}, 0);
        if (flush && running) chk("flush_req", {31'd0, imem_req}, 0);
        if (prev_pend && !flush) begin
            chk("req_hold", {31'd0, imem_req}, 1);
            chk("addr_hold", {16'd0, imem_addr}, {16'd0, prev_addr});
        end
        if (g) begin
            chk("grant_addr", {16'd0, imem_addr}, {16'd0, next_pc});
            chk("credit", {31'd0, (expq.size() + cur_out()) < DEPTH}, 1);
            outq.push_back('{imem_addr, epoch, cyc + lat});
            next_pc = next_pc + 16'd1;
            ngrants++;
        end
        prev_pend = imem_req && !g && !flush;
        prev_addr = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (rv) begin
            r = outq.pop_front();
            if (r.ep == epoch && !flush)
                expq.push_back('{r.addr, mem_word(r.addr)});
        end
        if (flush) begin
            expq.delete();
            epoch++;
            prev_pend = 1'b0;
            running   = sp;
            if (sp) next_pc = np;
        end
    endtask

    // Scoreboard monitor: compares the presented head against the model
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (mon_en) begin
            chk("instr_valid", {31'd0, instr_valid},
                {31'd0, expq.size() != 0});
            if (instr_valid && expq.size() != 0) begin
                e = expq[0];
                chk("instr_pc", {16'd0, instr_pc}, {16'd0, e.pc});
                chk("instr", instr, e.w);
                if (instr_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        set_pc = 0;
        new_pc = 0;
        request_pc = 0;
        instr_ready = 0;
        imem_gnt = 0;
        imem_rvalid = 0;
        imem_rdata = 0;
`ifdef IFETCH_BOOT_EN
        running = 1'b1;
        next_pc = BOOT;
`else
        running = 1'b0;
        next_pc = 16'h0000;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", {16'd0, instr_pc}, 0);
        chk("rst_addr", {16'd0, imem_addr}, {16'd0, next_pc});
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
`ifdef IFETCH_BOOT_EN
        chk("boot_req", {31'd0, imem_req}, 1);
        chk("boot_addr", {16'd0, imem_addr}, {16'd0, BOOT});
`else
        chk("noboot_req", {31'd0, imem_req}, 0);
`endif
        repeat (10) tick(0, 0, 0, 1, 1);

        tick(1, 16'h0010, 0, 1, 1);
        repeat (12) tick(0, 0, 0, 1, 1);

        tick(1, 16'h0010, 0, 0, 1);
        ngrants = 0;
        repeat (12) tick(0, 0, 0, 0, 1);
        chk("fill_grants", ngrants, DEPTH);
        chk("full_req", {31'd0, imem_req}, 0);
        repeat (12) tick(0, 0, 0, 1, 1);

        lat = 3;
        tick(1, 16'h0200, 0, 1, 1);
        repeat (2) tick(0, 0, 0, 1, 1);
        chk("inflight2", cur_out(), 2);
        tick(1, 16'h0100, 0, 1, 1);
        repeat (15) tick(0, 0, 0, 1, 1);

        lat = 1;
        tick(1, 16'h0300, 0, 0, 1);
        n = 0;
        while (expq.size() != 3 && n < 20) begin
            tick(0, 0, 0, 0, 1);
            n++;
        end
        chk("fill3", expq.size(), 3);
        tick(0, 0, 1, 0, 1);
        repeat (5) tick(0, 0, 0, 1, 1);

        tick(1, 16'hFFFE, 0, 1, 1);
        repeat (10) tick(0, 0, 0, 1, 1);

        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            tick($urandom_range(0, 99) < 3, 16'($urandom),
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 70);
        end
        repeat (20) tick(0, 0, 0, 1, 1);

        lat = 3;
        tick(1, 16'h0500, 0, 0, 1);
        repeat (3) tick(0, 0, 0, 0, 1);
        mon_en = 1'b0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, imem_req}, 0);
        chk("arst_valid", {31'd0, instr_valid}, 0);
`ifdef IFETCH_BOOT_EN
        chk("arst_addr", {16'd0, imem_addr}, {16'd0, BOOT});
`else
        chk("arst_addr", {16'd0, imem_addr}, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
